// File: rtl/ov7670_config_ctrl.sv
// ov7670_config_ctrl: walks a register table and issues one SCCB 3-phase write per entry to an OV7670.
module ov7670_config_ctrl #(
  parameter int         CLK_DIV      = 125,
  parameter int         DELAY_CYCLES = 50000,
  parameter logic [7:0] DEV_ADDR     = 8'h42
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_data,
  output logic        sioc,
  output logic        siod_out,
  output logic        siod_oe,
  output logic        busy,
  output logic        done
);
  localparam int QW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int DW = DELAY_CYCLES > 1 ? $clog2(DELAY_CYCLES) : 1;
  typedef enum logic [3:0] {IDLE, FETCH, WAIT_ROM, DECODE, START_C, SEND, STOP_C, DELAY, DONE} state_t;
  state_t state, next;
  logic [QW-1:0] qcnt;
  logic [1:0] quarter;
  logic [3:0] bitn;
  logic [1:0] byten;
  logic [DW-1:0] dcnt;
  logic [15:0] entry;
  logic [7:0] cur_byte;
  logic bus, q_end, bit_end;
  assign bus = state inside {START_C, SEND, STOP_C};
  assign q_end = qcnt == QW'(CLK_DIV - 1);
  assign bit_end = q_end && quarter == 2'd3;
  assign cur_byte = byten == 2'd0 ? DEV_ADDR : byten == 2'd1 ? entry[15:8] : entry[7:0];
  always_comb begin
    next = state;
    case (state)
      IDLE, DONE: next = start ? FETCH : state;
      FETCH:      next = WAIT_ROM;
      WAIT_ROM:   next = DECODE;
      DECODE:     next = entry == 16'hFFFF ? DONE : entry == 16'hFFF0 ? DELAY : START_C;
      START_C:    next = bit_end ? SEND : START_C;
      SEND:       next = bit_end && bitn == 4'd8 && byten == 2'd2 ? STOP_C : SEND;
      STOP_C:     next = bit_end ? FETCH : STOP_C;
      DELAY:      next = dcnt == DW'(DELAY_CYCLES - 1) ? FETCH : DELAY;
      default:    next = IDLE;
    endcase
  end
  // Bit 9 of each byte is the ack slot: the line is released and never sampled.
  always_comb begin
    busy = !(state inside {IDLE, DONE});
    done = state == DONE;
    sioc = state == START_C ? !quarter[1] : state == SEND ? quarter[1] : state == STOP_C ? quarter != 2'd0 : 1'b1;
    siod_out = state == START_C ? quarter == 2'd0 : state == SEND ? (bitn == 4'd8 || cur_byte[~bitn[2:0]]) :
               state == STOP_C ? quarter[1] : 1'b1;
    siod_oe = !(state == SEND && bitn == 4'd8);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rom_addr <= '0;
      qcnt     <= '0;
      quarter  <= '0;
      bitn     <= '0;
      byten    <= '0;
      dcnt     <= '0;
      entry    <= '0;
    end else begin
      state <= next;
      if (state inside {IDLE, DONE} && start) rom_addr <= '0;
      else if (state inside {STOP_C, DELAY} && next == FETCH) rom_addr <= rom_addr + 8'd1;
      if (state == WAIT_ROM) entry <= rom_data;
      qcnt    <= bus && !q_end ? qcnt + 1'b1 : '0;
      quarter <= !bus ? 2'd0 : q_end ? quarter + 2'd1 : quarter;
      bitn    <= state != SEND || !bit_end ? (state == SEND ? bitn : 4'd0) : bitn == 4'd8 ? 4'd0 : bitn + 4'd1;
      byten   <= state != SEND ? 2'd0 : bit_end && bitn == 4'd8 ? (byten == 2'd2 ? 2'd0 : byten + 2'd1) : byten;
      dcnt    <= state == DELAY ? dcnt + 1'b1 : '0;
    end
  end
endmodule

// File: tb/tb_ov7670_config_ctrl.sv
// tb_ov7670_config_ctrl: decodes the SCCB bus and checks it against a table-level model of the expected writes.
module tb_ov7670_config_ctrl;
  localparam int CD = 4, DC = 20, LIMIT = 20000;
  logic clk = 0, reset = 1, start = 0;
  logic [7:0] rom_addr;
  logic [15:0] rom_data;
  logic sioc, siod_out, siod_oe, busy, done;
  logic [15:0] rom [256];
  int total = 0, bad = 0;
  logic [7:0] got[$], exp_q[$], saved[$];
  int exp_lat, exp_w, exp_d, exp_addr;
  int edges, oe_err, max_idle, idle_run, max_busy, busy_run, nb;
  logic psioc = 1, psiod = 1;
  logic [7:0] sh;

  ov7670_config_ctrl #(.CLK_DIV(CD), .DELAY_CYCLES(DC), .DEV_ADDR(8'h42)) dut (
    .clk(clk), .reset(reset), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
    .sioc(sioc), .siod_out(siod_out), .siod_oe(siod_oe), .busy(busy), .done(done));

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr];

  // Bus decoder: start condition restarts bit framing, each rising sioc edge samples one bit.
  initial forever begin
    @(negedge clk);
    if (reset) begin
      nb = 0; idle_run = 0; busy_run = 0;
    end else begin
      if (psioc && sioc && psiod && !siod_out) nb = 0;
      if (!psioc && sioc) begin
        edges++;
        if (nb == 8) begin
          if (siod_oe) oe_err++;
          got.push_back(sh);
          nb = 0;
        end else begin
          if (!siod_oe) oe_err++;
          sh = {sh[6:0], siod_out};
          nb++;
        end
      end
      idle_run = (busy && sioc && siod_out && siod_oe) ? idle_run + 1 : 0;
      if (idle_run > max_idle) max_idle = idle_run;
      busy_run = busy ? busy_run + 1 : 0;
      if (busy_run > max_busy) max_busy = busy_run;
    end
    psioc = sioc;
    psiod = siod_out;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [15:0] t[$]);
    bit fin = 0;
    exp_q.delete(); exp_lat = 4; exp_w = 0; exp_d = 0; exp_addr = 0;
    for (int i = 0; i < t.size(); i++) begin
      if (fin) continue;
      if (t[i] == 16'hFFFF) begin
        exp_addr = i; fin = 1;
      end else if (t[i] == 16'hFFF0) begin
        exp_lat += DC + 3; exp_d++;
      end else begin
        exp_lat += 116 * CD + 3; exp_w++;
        exp_q.push_back(8'h42); exp_q.push_back(t[i][15:8]); exp_q.push_back(t[i][7:0]);
      end
    end
  endfunction

  task automatic load(input logic [15:0] t[$]);
    for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
    for (int i = 0; i < t.size(); i++) rom[i] = t[i];
    model(t);
  endtask

  task automatic run(input int poke, output int lat);
    logic [7:0] prev;
    bit addr_back = 0;
    got.delete(); edges = 0; oe_err = 0; max_idle = 0; max_busy = 0;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0; lat = 1;
    chk("start_busy", busy, 1);
    chk("start_done", done, 0);
    chk("start_addr", rom_addr, 0);
    prev = rom_addr;
    while (!done && lat < LIMIT) begin
      start = (lat == poke);
      @(negedge clk); lat++;
      if (busy && prev != 0 && rom_addr == 0) addr_back = 1;
      prev = rom_addr;
    end
    start = 0;
    chk("busy_fall", busy, 0);
    chk("addr_back", addr_back, 0);
  endtask

  task automatic common(input string tag);
    chk({tag, "_nbytes"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) chk({tag, "_byte"}, got[i], exp_q[i]);
    chk({tag, "_ack_oe"}, oe_err, 0);
    chk({tag, "_edges"}, edges, 28 * exp_w);
    chk({tag, "_busy_len"}, max_busy, exp_lat - 1);
    chk({tag, "_idle_gap"}, max_idle >= DC, exp_d > 0);
  endtask

  typedef struct { logic [63:0] t; int n; int lat; logic [7:0] addr; } vec_t;
  vec_t vecs[5];

  initial begin
    logic [15:0] q[$];
    int lat;
    vecs[0] = '{64'h1280_FFFF_0000_0000, 2, 471, 8'd1};
    vecs[1] = '{64'h1280_FFF0_1100_FFFF, 4, 961, 8'd3};
    vecs[2] = '{64'hFFFF_0000_0000_0000, 1, 4, 8'd0};
    vecs[3] = '{64'hFFF0_FFFF_0000_0000, 2, 27, 8'd1};
    vecs[4] = '{64'h3A04_1100_FFFF_0000, 3, 938, 8'd2};
    for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
    repeat (3) @(negedge clk);
    reset = 0;
    chk("rst_sioc", sioc, 1);
    chk("rst_siod", siod_out, 1);
    chk("rst_oe", siod_oe, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", rom_addr, 0);
    reset = 1; start = 1;
    @(negedge clk); reset = 0; start = 0;
    @(negedge clk);
    chk("start_with_reset", busy, 0);

    foreach (vecs[v]) begin
      q.delete();
      for (int i = 0; i < vecs[v].n; i++) q.push_back(vecs[v].t[63 - 16 * i -: 16]);
      load(q);
      run(0, lat);
      chk("vec_latency", lat, vecs[v].lat);
      chk("vec_addr", rom_addr, vecs[v].addr);
      common("vec");
    end

    // start while busy: once during the first write, once during the second
    q = '{16'h1280, 16'h1100, 16'hFFFF};
    load(q);
    run(100, lat);
    chk("busy_start_lat", lat, exp_lat);
    common("busy_start");
    run(600, lat);
    chk("busy_start2_lat", lat, exp_lat);
    common("busy_start2");
    saved = got;
    run(0, lat);
    chk("resend_nbytes", got.size(), saved.size());
    for (int i = 0; i < saved.size() && i < got.size(); i++) chk("resend_byte", got[i], saved[i]);

    // reset during the second byte, bit 4
    q = '{16'h1280, 16'hFFFF};
    load(q);
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    repeat (229) @(negedge clk);
    chk("pre_rst_sioc", sioc, 0);
    chk("pre_rst_busy", busy, 1);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("mid_rst_sioc", sioc, 1);
    chk("mid_rst_siod", siod_out, 1);
    chk("mid_rst_oe", siod_oe, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_addr", rom_addr, 0);
    run(0, lat);
    chk("replay_lat", lat, exp_lat);
    common("replay");

    for (int r = 0; r < 6; r++) begin
      int n = $urandom_range(1, 4);
      q.delete();
      for (int i = 0; i < n; i++)
        q.push_back($urandom_range(0, 3) == 0 ? 16'hFFF0 : {8'($urandom_range(0, 254)), 8'($urandom)});
      q.push_back(16'hFFFF);
      load(q);
      run(0, lat);
      chk("rand_lat", lat, exp_lat);
      chk("rand_addr", rom_addr, exp_addr);
      common("rand");
    end

    // address wrap: all delay entries, end marker planted at entry 1 once the walk reaches 255
    for (int i = 0; i < 256; i++) rom[i] = 16'hFFF0;
    edges = 0;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    lat = 0;
    while (rom_addr != 8'd255 && lat < 7000) begin @(negedge clk); lat++; end
    chk("wrap_reach_255", rom_addr, 255);
    rom[1] = 16'hFFFF;
    lat = 0;
    while (!done && lat < 200) begin @(negedge clk); lat++; end
    chk("wrap_done", done, 1);
    chk("wrap_addr", rom_addr, 1);
    chk("wrap_edges", edges, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
